// File: rtl/mips_mem_pkg.sv
// Shared opcodes, fault codes, FSM state and byte-lane helpers for the MIPS load/store path.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LL  = 6'b110000;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SC  = 6'b111000;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LL,
            OP_SB, OP_SH, OP_SW, OP_SC: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
    endfunction

    function automatic size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Loads always fetch the whole word; the lane is picked afterwards.
    function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] off);
        if (!is_store(op)) return 4'b1111;
        case (op_size(op))
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] wd);
        case (op_size(op))
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mips_load_align.sv
// Picks the addressed byte/half of a loaded word and sign- or zero-extends it.
module mips_load_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

        case (i_opcode)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: alignment/range check, req/ack memory handshake with timeout, load
// formatting and the LL/SC reservation.
module mips_lsu
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_AW      = 6,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [5:0]        ex_opcode,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              lsu_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [1:0]        wb_fault
);

    lsu_state_e        r_state, w_next;
    logic [5:0]        r_op;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [7:0]        r_cnt;
    logic [31:0]       r_wb_data;
    fault_e            r_fault;
    logic              r_resv_valid;
    logic [MEM_AW-1:0] r_resv_addr;

    logic              w_accept;
    logic              w_store;
    logic              w_misalign;
    logic              w_range;
    logic              w_sc_fail;
    logic              w_timeout;
    logic [MEM_AW-1:0] w_word;
    logic [31:0]       w_load_data;

    assign w_accept   = ex_valid && is_mem_op(ex_opcode) && (r_state == ST_IDLE);
    assign w_store    = is_store(r_op);
    assign w_misalign = misaligned(r_op, r_addr[1:0]);
    assign w_range    = |r_addr[31:MEM_AW+2];
    assign w_word     = r_addr[MEM_AW+1:2];
    assign w_sc_fail  = (r_op == OP_SC) && !(r_resv_valid && (r_resv_addr == w_word));
    assign w_timeout  = !mem_ack && (r_cnt == 8'(ACK_TIMEOUT - 1));

    mips_load_align u_align (
        .i_opcode (r_op),
        .i_offset (r_addr[1:0]),
        .i_word   (mem_rdata),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_wb_data    <= '0;
            r_fault      <= FAULT_OK;
            r_resv_valid <= 1'b0;
            r_resv_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= ex_opcode;
                r_addr  <= ex_addr;
                r_wdata <= ex_wdata;
            end
            case (r_state)
                ST_CHECK: begin
                    r_cnt     <= '0;
                    r_wb_data <= '0;
                    r_fault   <= FAULT_OK;
                    if (w_misalign)     r_fault      <= FAULT_MISALIGN;
                    else if (w_range)   r_fault      <= FAULT_RANGE;
                    else if (w_sc_fail) r_resv_valid <= 1'b0;
                end
                ST_ACCESS: begin
                    // Reservation only changes on a completed access; timeouts leave it alone.
                    if (mem_ack) begin
                        if (!w_store) r_wb_data <= w_load_data;
                        if (r_op == OP_SC) begin
                            r_wb_data    <= 32'd1;
                            r_resv_valid <= 1'b0;
                        end else if (r_op == OP_LL) begin
                            r_resv_valid <= 1'b1;
                            r_resv_addr  <= w_word;
                        end else if (w_store && (r_resv_addr == w_word)) begin
                            r_resv_valid <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_fault <= FAULT_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        lsu_busy  = (r_state != ST_IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        wb_valid  = 1'b0;
        wb_data   = '0;
        wb_fault  = '0;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_CHECK;
            ST_CHECK: w_next = (w_misalign || w_range || w_sc_fail) ? ST_RESP : ST_ACCESS;
            ST_ACCESS: begin
                mem_req   = 1'b1;
                mem_we    = w_store;
                mem_addr  = w_word;
                mem_be    = lane_be(r_op, r_addr[1:0]);
                mem_wdata = w_store ? lane_wdata(r_op, r_wdata) : '0;
                if (mem_ack || w_timeout) w_next = ST_RESP;
            end
            ST_RESP: begin
                wb_valid = 1'b1;
                wb_data  = r_wb_data;
                wb_fault = r_fault;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
